// File: rtl/pack_send_mc.sv
// pack_send_mc: packet output buffer with commit/discard framing, byte-wise
// LSB-first serialisation and periodic sync injection.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   sync         link-in-sync indicator; enables sync injection while high
//   WdAvail      PacketWd valid this cycle
//   PacketWd     packet word (8*WORD_BYTES bits)
//   PacketReset  discard the uncommitted frame
//   PacketCommit commit the current frame
//   DataVal      output byte
//   DataNext     consumer requests the next byte
//   DataReady    DataVal valid (one-cycle pulse)
//   DataOverf    stretched overflow indicator
//   DropCount    dropped frames, saturating at 0xFFFF
//   Level        committed words not yet fully read
module pack_send_mc #(
    parameter int WORD_BYTES    = 2,
    parameter int DEPTH_LOG2    = 12,
    parameter int ALIGN_LOG2    = 3,
    parameter int SYNC_LEN      = 4,
    parameter int SYNC_INTERVAL = 2097151,
    parameter int OVF_STRETCH   = 16777215
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sync,
    input  logic                    WdAvail,
    input  logic [8*WORD_BYTES-1:0] PacketWd,
    input  logic                    PacketReset,
    input  logic                    PacketCommit,
    output logic [7:0]              DataVal,
    input  logic                    DataNext,
    output logic                    DataReady,
    output logic                    DataOverf,
    output logic [15:0]             DropCount,
    output logic [DEPTH_LOG2:0]     Level
);

    localparam int W   = 8 * WORD_BYTES;
    localparam int BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int SIW = $clog2(SYNC_LEN);
    localparam int SAW = (SYNC_INTERVAL > 0) ? $clog2(SYNC_INTERVAL + 1) : 1;
    localparam int OCW = (OVF_STRETCH > 0) ? $clog2(OVF_STRETCH + 1) : 1;

    localparam logic [DEPTH_LOG2-1:0] ALIGN_MASK = DEPTH_LOG2'((1 << ALIGN_LOG2) - 1);
    localparam logic [BIW-1:0]        LAST_BYTE  = BIW'(WORD_BYTES - 1);
    localparam logic [SIW-1:0]        LAST_SYNC  = SIW'(SYNC_LEN - 1);

    typedef enum logic {RD_IDLE, RD_SYNC} rdState_t;

    logic [W-1:0]          mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wp, wpFrame, rp;
    logic                  holdoff;
    logic [OCW-1:0]        ovfCnt;
    logic [BIW-1:0]        byteIdx;
    logic [SIW-1:0]        syncIdx;
    logic [SAW-1:0]        syncArm;
    rdState_t              state, nextState;

    logic       full, wordTry, memWe, ovfLoad;
    logic       accept, notEmpty, enterSync;
    logic       issueData, issueSync, syncDone;
    logic [W-1:0] wordRd;
    logic [7:0]   byteRd;

    // ---------------- write side ----------------
    // Commit and reset both take precedence over an incoming word.
    assign full    = (wpFrame + DEPTH_LOG2'(1)) == rp;
    assign wordTry = !PacketCommit && !PacketReset && WdAvail && !holdoff;
    assign memWe   = wordTry && !full;
    assign ovfLoad = wordTry && full;

    always_ff @(posedge clk) begin
        if (memWe) mem[wpFrame] <= PacketWd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp        <= '0;
            wpFrame   <= '0;
            holdoff   <= 1'b0;
            DropCount <= '0;
            ovfCnt    <= '0;
        end else begin
            if (PacketCommit) begin
                if (holdoff) begin
                    // Frame was truncated by overflow: roll back and count it.
                    wpFrame <= wp;
                    holdoff <= 1'b0;
                    if (DropCount != '1) DropCount <= DropCount + 16'd1;
                end else begin
                    wp <= wpFrame;
                end
            end else if (PacketReset) begin
                wpFrame <= wp;
                holdoff <= 1'b0;
            end else if (ovfLoad) begin
                holdoff <= 1'b1;
            end else if (memWe) begin
                wpFrame <= wpFrame + DEPTH_LOG2'(1);
            end

            if (ovfLoad)            ovfCnt <= OCW'(OVF_STRETCH);
            else if (ovfCnt != '0)  ovfCnt <= ovfCnt - OCW'(1);
        end
    end

    assign DataOverf = (ovfCnt != '0);
    assign Level     = {1'b0, wp - rp};

    // ---------------- read side ----------------
    assign accept    = DataNext && !DataReady;
    assign notEmpty  = (wp != rp);
    assign enterSync = (byteIdx == '0) && ((rp & ALIGN_MASK) == '0) &&
                       (syncArm == '0) && sync;
    assign wordRd    = mem[rp];
    assign byteRd    = 8'(wordRd >> {byteIdx, 3'b000});

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RD_IDLE;
        else        state <= nextState;
    end

    // Sync entry does not wait for DataNext; sync bytes are then handed out
    // on accepted requests like data, and a started sequence always finishes.
    always_comb begin
        nextState = state;
        issueData = 1'b0;
        issueSync = 1'b0;
        syncDone  = 1'b0;
        case (state)
            RD_IDLE: begin
                if (enterSync)              nextState = RD_SYNC;
                else if (accept && notEmpty) issueData = 1'b1;
            end
            RD_SYNC: begin
                if (accept) begin
                    issueSync = 1'b1;
                    if (syncIdx == LAST_SYNC) begin
                        syncDone  = 1'b1;
                        nextState = RD_IDLE;
                    end
                end
            end
            default: nextState = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rp        <= '0;
            byteIdx   <= '0;
            syncIdx   <= '0;
            syncArm   <= '0;
            DataVal   <= '0;
            DataReady <= 1'b0;
        end else begin
            DataReady <= issueData || issueSync;

            if (issueSync) begin
                DataVal <= (syncIdx == LAST_SYNC) ? 8'h7F : 8'hFF;
                syncIdx <= (syncIdx == LAST_SYNC) ? '0 : syncIdx + SIW'(1);
            end

            if (issueData) begin
                DataVal <= byteRd;
                if (byteIdx == LAST_BYTE) begin
                    byteIdx <= '0;
                    rp      <= rp + DEPTH_LOG2'(1);
                end else begin
                    byteIdx <= byteIdx + BIW'(1);
                end
            end

            if (syncDone)                              syncArm <= SAW'(SYNC_INTERVAL);
            else if (state != RD_SYNC && syncArm != '0) syncArm <= syncArm - SAW'(1);
        end
    end

endmodule

// File: tb/tb_pack_send_mc.sv
// Testbench for pack_send_mc: directed scenarios with literal expectations
// plus randomized traffic, all checked every cycle against a queue-based
// behavioural model of the buffer.
module tb_pack_send_mc;

    localparam int WB = 2;
    localparam int DL = 4;
    localparam int AL = 2;
    localparam int SL = 4;
    localparam int SI = 100;
    localparam int OS = 20;
    localparam int N  = 1 << DL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic        WdAvail = 1'b0;
    logic [15:0] PacketWd = '0;
    logic        PacketReset = 1'b0;
    logic        PacketCommit = 1'b0;
    logic        DataNext = 1'b0;
    logic [7:0]  DataVal;
    logic        DataReady;
    logic        DataOverf;
    logic [15:0] DropCount;
    logic [DL:0] Level;

    pack_send_mc #(
        .WORD_BYTES(WB), .DEPTH_LOG2(DL), .ALIGN_LOG2(AL),
        .SYNC_LEN(SL), .SYNC_INTERVAL(SI), .OVF_STRETCH(OS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .WdAvail(WdAvail),
        .PacketWd(PacketWd), .PacketReset(PacketReset),
        .PacketCommit(PacketCommit), .DataVal(DataVal), .DataNext(DataNext),
        .DataReady(DataReady), .DataOverf(DataOverf), .DropCount(DropCount),
        .Level(Level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // cq: committed words, front = word currently being read
    // pq: words of the open (uncommitted) frame
    int cq[$];
    int pq[$];
    bit mHold, mInSync, mReady;
    int mBytePos, mRp, mArm, mSyncN, mOvf, mDrop, mVal;

    always @(posedge clk) begin
        bit full, avail, accept, ovfLoad, newReady;
        if (!rst_n) begin
            cq.delete(); pq.delete();
            mHold = 0; mInSync = 0; mReady = 0;
            mBytePos = 0; mRp = 0; mArm = 0; mSyncN = 0; mOvf = 0; mDrop = 0; mVal = 0;
        end else begin
            full     = (cq.size() + pq.size()) == N - 1;
            avail    = cq.size() > 0;
            accept   = DataNext && !mReady;
            ovfLoad  = 0;
            newReady = 0;

            if (mInSync) begin
                if (accept) begin
                    mVal = (mSyncN == SL - 1) ? 'h7F : 'hFF;
                    newReady = 1;
                    if (mSyncN == SL - 1) begin
                        mInSync = 0; mSyncN = 0; mArm = SI;
                    end else begin
                        mSyncN++;
                    end
                end
            end else begin
                if (mBytePos == 0 && (mRp % (1 << AL)) == 0 && mArm == 0 && sync) begin
                    mInSync = 1;
                end else if (accept && avail) begin
                    mVal = (cq[0] >> (8 * mBytePos)) & 'hFF;
                    newReady = 1;
                    mBytePos++;
                    if (mBytePos == WB) begin
                        mBytePos = 0;
                        void'(cq.pop_front());
                        mRp = (mRp + 1) % N;
                    end
                end
                if (mArm > 0) mArm--;
            end
            mReady = newReady;

            if (PacketCommit) begin
                if (mHold) begin
                    pq.delete(); mHold = 0;
                    if (mDrop < 65535) mDrop++;
                end else begin
                    foreach (pq[i]) cq.push_back(pq[i]);
                    pq.delete();
                end
            end else if (PacketReset) begin
                pq.delete(); mHold = 0;
            end else if (WdAvail && !mHold) begin
                if (full) begin mHold = 1; ovfLoad = 1; end
                else      pq.push_back(int'(PacketWd));
            end
            if (ovfLoad)       mOvf = OS;
            else if (mOvf > 0) mOvf--;
        end
    end

    // ---------------- compare + byte capture ----------------
    logic [7:0] capQ[$];
    logic [7:0] expQ[$];

    always @(negedge clk) begin
        check("DataReady", 32'(DataReady), 32'(mReady));
        check("DataVal",   32'(DataVal),   mVal);
        check("DataOverf", 32'(DataOverf), 32'(mOvf != 0));
        check("DropCount", 32'(DropCount), mDrop);
        check("Level",     32'(Level),     cq.size());
        if (DataReady === 1'b1) capQ.push_back(DataVal);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clearInputs();
        WdAvail = 0; PacketWd = '0; PacketReset = 0; PacketCommit = 0; DataNext = 0; sync = 0;
    endtask

    task automatic doReset();
        clearInputs();
        rst_n = 0;
        cyc(2);
        rst_n = 1;
        capQ.delete();
    endtask

    task automatic writeWord(input logic [15:0] w);
        WdAvail = 1; PacketWd = w; cyc(); WdAvail = 0;
    endtask

    task automatic commit();
        PacketCommit = 1; cyc(); PacketCommit = 0;
    endtask

    task automatic readN(input int n);
        DataNext = 1; cyc(n); DataNext = 0;
    endtask

    task automatic checkCap(input string name);
        check({name, "_count"}, capQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < capQ.size(); i++)
            check(name, 32'(capQ[i]), 32'(expQ[i]));
    endtask

    initial begin
        // A: plain data path, LSB first
        doReset();
        check("rst_DataReady", 32'(DataReady), 0);
        check("rst_DataVal",   32'(DataVal),   0);
        check("rst_Level",     32'(Level),     0);
        check("rst_DropCount", 32'(DropCount), 0);
        check("rst_DataOverf", 32'(DataOverf), 0);
        writeWord(16'h1122); writeWord(16'h3344); writeWord(16'h5566); writeWord(16'h7788);
        commit();
        check("A_level4", 32'(Level), 4);
        readN(20);
        expQ = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77};
        checkCap("A_bytes");
        check("A_level0", 32'(Level), 0);
        check("A_idle_ready", 32'(DataReady), 0);

        // B: sync first, then data; second sync later with sync dropping mid-way
        doReset();
        sync = 1;
        for (int i = 0; i < 8; i++) writeWord({8'(2 * i + 1), 8'(2 * i)});
        commit();
        readN(44);
        expQ = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
        for (int i = 0; i < 16; i++) expQ.push_back(8'(i));
        checkCap("B_sync_data");
        cyc(120);
        capQ.delete();
        readN(4);
        sync = 0;
        readN(10);
        expQ = '{8'hFF, 8'hFF, 8'hFF, 8'h7F};
        checkCap("B_sync_drop");

        // C: discard an open frame
        doReset();
        writeWord(16'h1111); writeWord(16'h2222); writeWord(16'h3333);
        PacketReset = 1; cyc(); PacketReset = 0;
        writeWord(16'hABCD);
        commit();
        readN(10);
        expQ = '{8'hCD, 8'hAB};
        checkCap("C_bytes");
        check("C_drop", 32'(DropCount), 0);

        // D: overflow drops only the open frame
        doReset();
        writeWord(16'h1122); writeWord(16'h3344); writeWord(16'h5566); writeWord(16'h7788);
        commit();
        WdAvail = 1;
        for (int i = 0; i < 13; i++) begin PacketWd = 16'hE000 + 16'(i); cyc(); end
        WdAvail = 0;
        check("D_ovf", 32'(DataOverf), 1);
        check("D_level_pre", 32'(Level), 4);
        commit();
        check("D_drop", 32'(DropCount), 1);
        check("D_level", 32'(Level), 4);
        readN(20);
        expQ = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55, 8'h88, 8'h77};
        checkCap("D_bytes");
        cyc(30);
        check("D_ovf_end", 32'(DataOverf), 0);

        // E: reset mid-frame with data flowing
        writeWord(16'h0102); writeWord(16'h0304);
        commit();
        WdAvail = 1; PacketWd = 16'h0506; DataNext = 1;
        cyc(3);
        rst_n = 0;
        cyc();
        check("E_DataReady", 32'(DataReady), 0);
        check("E_DataVal",   32'(DataVal),   0);
        check("E_DataOverf", 32'(DataOverf), 0);
        check("E_DropCount", 32'(DropCount), 0);
        check("E_Level",     32'(Level),     0);
        rst_n = 1;
        clearInputs();
        cyc(2);

        // F: randomized traffic, checked by the model every cycle
        sync = 1;
        for (int c = 0; c < 4000; c++) begin
            rst_n        = ($urandom_range(0, 799) != 0);
            if ($urandom_range(0, 199) == 0) sync = ~sync;
            WdAvail      = 1'($urandom_range(0, 1));
            PacketWd     = 16'($urandom);
            PacketCommit = ($urandom_range(0, 11) == 0);
            PacketReset  = ($urandom_range(0, 29) == 0);
            DataNext     = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                : ($urandom_range(0, 5) == 0);
            cyc();
        end
        clearInputs();
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pack_send_mc.md
Name: pack_send_mc

Overview:
- Next-generation packet output buffer. Accepts packet words of parametrised width from the packet processor and holds each packet uncommitted until commit or discard.
- Serialises committed data as bytes, LSB first, to the serial/USB handler, and periodically injects a sync sequence.
- Single clock domain. On overflow it drops only the offending frame, not the whole buffer, and it counts dropped frames.

Parameters:
WORD_BYTES, 2, bytes per input word (1..4)
DEPTH_LOG2, 12, log2 of buffer depth in words
ALIGN_LOG2, 3, log2 of frame alignment in words; sync may only be injected at read pointer multiples of 2^ALIGN_LOG2
SYNC_LEN, 4, sync sequence length in bytes (SYNC_LEN-1 × 0xFF, then 0x7F); range 2..8
SYNC_INTERVAL, 2097151, clocks between end of one sync sequence and eligibility of the next
OVF_STRETCH, 16777215, clocks the ovf indicator is held after a drop

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
sync  in  1  link-in-sync indicator; sync injection enabled while high
WdAvail  in  1  PacketWd valid this cycle
PacketWd  in  8*WORD_BYTES  packet word
PacketReset  in  1  discard uncommitted frame
PacketCommit  in  1  commit current frame
DataVal  out  8  output byte
DataNext  in  1  consumer requests next byte
DataReady  out  1  DataVal valid (one-cycle pulse)
DataOverf  out  1  stretched overflow indicator
DropCount  out  16  frames dropped, saturating at 0xFFFF
Level  out  DEPTH_LOG2+1  committed words not yet fully read

Behaviour:
- Reset (rst_n low at posedge): wp, wpFrame, rp, byteIdx, syncIdx, syncArm, ovfCnt, DropCount and holdoff are all cleared to 0. DataVal=0, DataReady=0, DataOverf=0. Memory contents are don't-care. Reset mid-frame or mid-sync abandons everything silently.
- Pointers: wpFrame (next write), wp (committed end), rp (read word). All are DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2. Capacity is 2^DEPTH_LOG2-1 words.
- Write side priority per cycle:
  1. PacketCommit: if holdoff, set wpFrame<=wp, clear holdoff and increment DropCount (a truncated frame is dropped); else set wp<=wpFrame.
  2. else PacketReset: set wpFrame<=wp and clear holdoff; DropCount unchanged.
  3. else WdAvail && !holdoff: if wpFrame+1==rp (full), set holdoff<=1, load ovfCnt<=OVF_STRETCH and write nothing; else mem[wpFrame]<=PacketWd and wpFrame<=wpFrame+1.
- In every case, WdAvail in the same cycle as commit or reset is ignored. A word arriving while holdoff is set is ignored.
- Committed data already in the buffer is never lost through overflow.
- Level = wp-rp (modulo, zero-extended). Empty when wp==rp.
- ovfCnt decrements to 0. DataOverf=(ovfCnt!=0). A new overflow reloads ovfCnt.
- Read handshake:
  - DataReady is a single-cycle pulse. A byte is issued only on a cycle where DataNext=1 and DataReady=0, so the maximum rate is one byte per 2 clocks.
  - If DataNext=1 but nothing is issuable, DataReady<=0.
  - Latency is 1 clock from the accepting DataNext edge to DataReady.
- Read state machine:
  - IDLE→SYNC when byteIdx==0, rp[ALIGN_LOG2-1:0]==0, syncArm==0 and sync=1.
  - SYNC emits syncIdx-selected bytes (0xFF, …, 0x7F for the last). After the last byte it sets syncArm<=SYNC_INTERVAL, syncIdx<=0 and returns to IDLE.
  - A started sequence always completes, even if sync drops.
  - syncArm decrements to 0 every clock outside SYNC.
- Data issue (IDLE only, not entering SYNC):
  - Issue when wp!=rp. DataVal<=mem[rp] byte byteIdx.
  - byteIdx increments; on WORD_BYTES-1 it wraps to 0 and rp<=rp+1.
  - A partially read word is always completed before SYNC can start.
- Simultaneous commit and read of the same cycle: the read uses pre-update wp, so the new data is visible the next cycle.

Test Plan:
- Reset, sync=0, write 4 words 0x1122,0x3344,0x5566,0x7788, commit, pulse DataNext -> bytes 22,11,44,33,66,55,88,77, each with a one-cycle DataReady. Level 4→0; no DataReady while empty.
- sync=1 after reset, commit 8 words -> first 4 bytes FF,FF,FF,7F, then data. No further sync until SYNC_INTERVAL (set 100) elapses and rp is 8-aligned.
- Write 3 words, PacketReset, write 1 word 0xABCD, commit -> only bytes CD,AB are output; DropCount=0.
- DEPTH_LOG2=3: commit 4 words, then stream 5 words with no reads -> holdoff on the 4th (full). Commit -> frame dropped, DropCount=1, DataOverf high for OVF_STRETCH cycles. The original 4 words read out intact.
- sync drops after 2nd sync byte -> FF,7F still complete the sequence. rst_n low mid-frame -> all outputs 0 next cycle and Level=0.
